// File: rtl/uart_cmd_exec.sv
// Executes framed UART commands: bus write/read, ping or reject, then streams
// a three-byte response (status, LSB, MSB) to the UART transmitter.
module uart_cmd_exec #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmdUpdate,
  input  logic [7:0]  cmd,
  input  logic [7:0]  addrLsb,
  input  logic [7:0]  addrMsb,
  input  logic [7:0]  dataLsb,
  input  logic [7:0]  dataMsb,
  output logic        busReq,
  output logic        busWe,
  output logic [15:0] busAddr,
  output logic [15:0] busWdata,
  input  logic [15:0] busRdata,
  input  logic        busAck,
  output logic        txStart,
  output logic [7:0]  txData,
  input  logic        txBusy,
  output logic        busy,
  output logic [7:0]  dropCnt
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] BUS     = 3'd1;
  localparam logic [2:0] TX_SEND = 3'd2;
  localparam logic [2:0] TX_HOLD = 3'd3;
  localparam logic [2:0] TX_WAIT = 3'd4;

  // The last BUS cycle index without ack; reaching it means TIMEOUT cycles have elapsed.
  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

  logic [2:0]  r_state;
  logic [7:0]  r_cmd;
  logic [15:0] r_busAddr;
  logic [15:0] r_busWdata;
  logic        r_busReq;
  logic        r_busWe;
  logic [15:0] r_waitCnt;
  logic [23:0] r_resp;
  logic [1:0]  r_idx;
  logic        r_txStart;
  logic [7:0]  r_txData;
  logic [7:0]  r_dropCnt;
  logic [7:0]  w_txByte;

  always_comb begin
    w_txByte = r_resp[7:0];
    case (r_idx)
      2'd0:    w_txByte = r_resp[7:0];
      2'd1:    w_txByte = r_resp[15:8];
      default: w_txByte = r_resp[23:16];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cmd      <= 8'h00;
      r_busAddr  <= 16'h0000;
      r_busWdata <= 16'h0000;
      r_busReq   <= 1'b0;
      r_busWe    <= 1'b0;
      r_waitCnt  <= 16'h0000;
      r_resp     <= 24'h000000;
      r_idx      <= 2'd0;
      r_txStart  <= 1'b0;
      r_txData   <= 8'h00;
      r_dropCnt  <= 8'h00;
    end else begin
      r_txStart <= 1'b0;
      if (cmdUpdate && (r_state != IDLE) && (r_dropCnt != 8'hFF))
        r_dropCnt <= r_dropCnt + 8'd1;

      case (r_state)
        IDLE: begin
          if (cmdUpdate) begin
            r_busAddr  <= {addrMsb, addrLsb};
            r_busWdata <= {dataMsb, dataLsb};
            r_cmd      <= cmd;
            r_idx      <= 2'd0;
            r_waitCnt  <= 16'h0000;
            case (cmd)
              8'hA0: begin
                r_busWe  <= 1'b1;
                r_busReq <= 1'b1;
                r_state  <= BUS;
              end
              8'hA1: begin
                r_busWe  <= 1'b0;
                r_busReq <= 1'b1;
                r_state  <= BUS;
              end
              8'hA2: begin
                r_resp  <= {addrMsb, addrLsb, 8'h55};
                r_state <= TX_SEND;
              end
              default: begin
                r_resp  <= {16'h0000, 8'hCC};
                r_state <= TX_SEND;
              end
            endcase
          end
        end
        // Ack is checked first so it wins over a coincident timeout.
        BUS: begin
          if (busAck) begin
            r_busReq <= 1'b0;
            r_resp   <= (r_cmd == 8'hA0) ? {r_busWdata, 8'h55} : {busRdata, 8'h55};
            r_state  <= TX_SEND;
          end else if (r_waitCnt == LAST_WAIT) begin
            r_busReq <= 1'b0;
            r_resp   <= {16'h0000, 8'hEE};
            r_state  <= TX_SEND;
          end else begin
            r_waitCnt <= r_waitCnt + 16'd1;
          end
        end
        TX_SEND: begin
          if (!txBusy) begin
            r_txStart <= 1'b1;
            r_txData  <= w_txByte;
            r_state   <= TX_HOLD;
          end
        end
        // One blind cycle lets the transmitter raise txBusy after the start pulse.
        TX_HOLD: r_state <= TX_WAIT;
        TX_WAIT: begin
          if (!txBusy) begin
            if (r_idx < 2'd2) begin
              r_idx   <= r_idx + 2'd1;
              r_state <= TX_SEND;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busReq   = r_busReq;
  assign busWe    = r_busWe;
  assign busAddr  = r_busAddr;
  assign busWdata = r_busWdata;
  assign txStart  = r_txStart;
  assign txData   = r_txData;
  assign busy     = (r_state != IDLE);
  assign dropCnt  = r_dropCnt;

endmodule
